// File: rtl/fifo_rd_ser_pkg.sv
// Shared definitions for fifo_rd_serializer: slot count, chunk index width
// and the parameter legality check.
package fifo_rd_ser_pkg;

    localparam int SLOTS = 2;

    function automatic int idx_width(input int ratio);
        return (ratio <= 1) ? 1 : $clog2(ratio);
    endfunction

    function automatic bit params_legal(input int data_width, input int out_width, input int ratio);
        return (ratio >= 1) && (data_width == out_width * ratio);
    endfunction

endpackage

// File: rtl/fifo_rd_ser_slots.sv
// Occupancy tracking for the landing (LR) and shift (SR) slots plus the word
// in flight from the fifo; decides when to pop and where the next word lands.
module fifo_rd_ser_slots
    import fifo_rd_ser_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic fifo_empty,
    input  logic out_ready,
    input  logic last_chunk,
    output logic fifo_pop,
    output logic sr_valid,
    output logic sr_load_lr,
    output logic sr_load_in,
    output logic lr_load_in
);

    logic       inflight_q, inflight_d;
    logic       lr_valid_q, lr_valid_d;
    logic       sr_valid_q, sr_valid_d;
    logic [1:0] used;
    logic       free_now;
    logic       sr_free;

    // Pop gating and slot routing for the word arriving this cycle.
    always_comb begin
        free_now   = sr_valid_q && out_ready && last_chunk;
        sr_free    = !sr_valid_q || free_now;
        used       = {1'b0, inflight_q} + {1'b0, lr_valid_q} + {1'b0, sr_valid_q};
        // free_now implies sr_valid_q, so the subtraction cannot wrap.
        fifo_pop   = !reset && !fifo_empty && ((used - {1'b0, free_now}) < 2'(SLOTS));
        inflight_d = fifo_pop;
        sr_load_lr = 1'b0;
        sr_load_in = 1'b0;
        lr_load_in = 1'b0;
        lr_valid_d = lr_valid_q;
        sr_valid_d = sr_valid_q && !free_now;
        if (sr_free && lr_valid_q) begin
            sr_load_lr = 1'b1;
            sr_valid_d = 1'b1;
            lr_load_in = inflight_q;
            lr_valid_d = inflight_q;
        end else if (sr_free && inflight_q) begin
            sr_load_in = 1'b1;
            sr_valid_d = 1'b1;
        end else if (inflight_q) begin
            lr_load_in = 1'b1;
            lr_valid_d = 1'b1;
        end else begin
            lr_valid_d = lr_valid_q;
        end
    end

    // Occupancy state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= 1'b0;
            lr_valid_q <= 1'b0;
            sr_valid_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            lr_valid_q <= lr_valid_d;
            sr_valid_q <= sr_valid_d;
        end
    end

    assign sr_valid = sr_valid_q;

endmodule

// File: rtl/fifo_rd_serializer.sv
// Pops the upstream fifo and streams each word LSB-first as RATIO chunks of
// OUT_WIDTH bits. Define FIFO_RD_SER_LAST_EN to add the out_last port.
module fifo_rd_serializer
    import fifo_rd_ser_pkg::*;
#(
    parameter int OUT_WIDTH  = 16,
    parameter int RATIO      = 4,
    parameter int DATA_WIDTH = OUT_WIDTH * RATIO
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_pop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data
`ifdef FIFO_RD_SER_LAST_EN
    ,
    output logic                  out_last
`endif
);

    localparam int              IDXW     = idx_width(RATIO);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(RATIO - 1);

    generate
        if (!params_legal(DATA_WIDTH, OUT_WIDTH, RATIO)) begin : g_bad_params
            $error("fifo_rd_serializer: need RATIO >= 1 and DATA_WIDTH == OUT_WIDTH*RATIO");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic [DATA_WIDTH-1:0] lr_q, lr_d;
    logic [IDXW-1:0]       chunk_idx_q, chunk_idx_d;
    logic                  sr_valid;
    logic                  sr_load_lr;
    logic                  sr_load_in;
    logic                  lr_load_in;
    logic                  last_chunk;
    logic                  hs;

    assign last_chunk = (chunk_idx_q == LAST_IDX);
    assign out_valid  = sr_valid;
    assign hs         = sr_valid && out_ready;

    fifo_rd_ser_slots u_slots (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .out_ready  (out_ready),
        .last_chunk (last_chunk),
        .fifo_pop   (fifo_pop),
        .sr_valid   (sr_valid),
        .sr_load_lr (sr_load_lr),
        .sr_load_in (sr_load_in),
        .lr_load_in (lr_load_in)
    );

    // Word movement between slots and chunk shifting.
    always_comb begin
        if (lr_load_in) begin
            lr_d = fifo_data;
        end else begin
            lr_d = lr_q;
        end
        if (sr_load_lr) begin
            sr_d = lr_q;
        end else if (sr_load_in) begin
            sr_d = fifo_data;
        end else if (hs && !last_chunk) begin
            sr_d = sr_q >> OUT_WIDTH;
        end else begin
            sr_d = sr_q;
        end
        if (hs) begin
            chunk_idx_d = last_chunk ? {IDXW{1'b0}} : chunk_idx_q + IDXW'(1);
        end else begin
            chunk_idx_d = chunk_idx_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q        <= {DATA_WIDTH{1'b0}};
            lr_q        <= {DATA_WIDTH{1'b0}};
            chunk_idx_q <= {IDXW{1'b0}};
        end else begin
            sr_q        <= sr_d;
            lr_q        <= lr_d;
            chunk_idx_q <= chunk_idx_d;
        end
    end

    assign out_data = sr_q[OUT_WIDTH-1:0];

`ifdef FIFO_RD_SER_LAST_EN
    assign out_last = sr_valid && last_chunk;
`endif

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Scoreboard bench for fifo_rd_serializer: RATIO=4 and RATIO=1 instances, each
// fed by a one-cycle-latency fifo model.
module tb_fifo_rd_serializer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // RATIO = 4 instance
    logic        a_empty, a_pop, a_valid, a_ready, a_last;
    logic [63:0] a_data = 64'h0;
    logic [15:0] a_out;
    logic [63:0] a_mem [0:63];
    int          a_wr = 0, a_rd = 0, a_pops = 0;
    logic [15:0] a_exp[$];
    bit          a_exp_last[$];
    logic        a_hold = 1'b0;
    logic [15:0] a_prev = 16'h0;
    logic [15:0] a_e;
    bit          a_el;

    // RATIO = 1 instance
    logic        b_empty, b_pop, b_valid, b_ready, b_last;
    logic [15:0] b_data = 16'h0;
    logic [15:0] b_out;
    logic [15:0] b_mem [0:15];
    int          b_wr = 0, b_rd = 0;
    logic [15:0] b_exp[$];
    logic [15:0] b_e;

    assign a_empty = (a_rd == a_wr);
    assign b_empty = (b_rd == b_wr);

    fifo_rd_serializer #(.OUT_WIDTH(16), .RATIO(4), .DATA_WIDTH(64)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (a_empty),
        .fifo_data  (a_data),
        .fifo_pop   (a_pop),
        .out_valid  (a_valid),
        .out_ready  (a_ready),
        .out_data   (a_out)
`ifdef FIFO_RD_SER_LAST_EN
        ,
        .out_last   (a_last)
`endif
    );

    fifo_rd_serializer #(.OUT_WIDTH(16), .RATIO(1), .DATA_WIDTH(16)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (b_empty),
        .fifo_data  (b_data),
        .fifo_pop   (b_pop),
        .out_valid  (b_valid),
        .out_ready  (b_ready),
        .out_data   (b_out)
`ifdef FIFO_RD_SER_LAST_EN
        ,
        .out_last   (b_last)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // fifo models: data_out valid the cycle after an accepted pop; reset empties
    always @(posedge clk) begin
        if (reset) begin
            a_rd <= a_wr;
            b_rd <= b_wr;
        end else begin
            if (a_pop) begin
                a_data <= a_mem[a_rd];
                a_rd   <= a_rd + 1;
                a_pops <= a_pops + 1;
            end
            if (b_pop) begin
                b_data <= b_mem[b_rd];
                b_rd   <= b_rd + 1;
            end
        end
    end

    // monitor A: scoreboard pop/compare, stall stability, no pop while empty
    always @(negedge clk) begin
        if (reset) begin
            a_hold = 1'b0;
        end else begin
            if (a_empty) chk("a_pop_while_empty", a_pop, 0);
            if (a_hold) begin
                chk("a_hold_valid", a_valid, 1);
                chk("a_hold_data", a_out, a_prev);
            end
            if (a_valid && a_ready) begin
                chk("a_chunk_expected", a_exp.size() != 0, 1);
                if (a_exp.size() != 0) begin
                    a_e  = a_exp.pop_front();
                    a_el = a_exp_last.pop_front();
                    chk("a_chunk_data", a_out, a_e);
`ifdef FIFO_RD_SER_LAST_EN
                    chk("a_chunk_last", a_last, a_el);
`endif
                end
            end
            a_hold = a_valid && !a_ready;
            a_prev = a_out;
        end
    end

    // monitor B
    always @(negedge clk) begin
        if (!reset) begin
            if (b_empty) chk("b_pop_while_empty", b_pop, 0);
            if (b_valid && b_ready) begin
                chk("b_chunk_expected", b_exp.size() != 0, 1);
                if (b_exp.size() != 0) begin
                    b_e = b_exp.pop_front();
                    chk("b_chunk_data", b_out, b_e);
`ifdef FIFO_RD_SER_LAST_EN
                    chk("b_chunk_last", b_last, 1);
`endif
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [63:0] w);
        a_mem[a_wr] = w;
        a_wr++;
        for (int k = 0; k < 4; k++) begin
            a_exp.push_back(w[k*16 +: 16]);
            a_exp_last.push_back(k == 3);
        end
    endtask

    task automatic push_b(input logic [15:0] w);
        b_mem[b_wr] = w;
        b_wr++;
        b_exp.push_back(w);
    endtask

    task automatic drain_a(input string name);
        int c;
        c = 0;
        while (a_exp.size() != 0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        repeat (4) @(negedge clk);
        chk(name, a_exp.size(), 0);
    endtask

    function automatic logic [63:0] mk_word(input int base);
        logic [63:0] w;
        for (int k = 0; k < 4; k++) w[k*16 +: 16] = 16'(base + k);
        return w;
    endfunction

    initial begin
        int p0, first, last, cnt, pfirst, plast, pcnt;
        reset   = 1'b1;
        a_ready = 1'b1;
        b_ready = 1'b1;

        // reset state; a word present during reset must not be popped
        step(1);
        a_mem[a_wr] = 64'hdead_beef_0bad_f00d;
        a_wr++;
        @(negedge clk);
        chk("rst_pop_forced", a_pop, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_data", a_out, 0);
`ifdef FIFO_RD_SER_LAST_EN
        chk("rst_last", a_last, 0);
`endif
        step(1);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_idle_pop", a_pop, 0);
        chk("rst_idle_valid", b_valid, 0);

        // single word: 1 pop, chunks 1..4 from 2 cycles after the pop
        step(1);
        p0 = a_pops;
        push_a(64'h0004_0003_0002_0001);
        @(negedge clk);
        chk("t1_pop", a_pop, 1);
        @(negedge clk);
        chk("t1_valid_latency", a_valid, 0);
        chk("t1_no_second_pop", a_pop, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_valid", a_valid, 1);
`ifdef FIFO_RD_SER_LAST_EN
            chk("t1_last", a_last, k == 3);
`endif
        end
        @(negedge clk);
        chk("t1_done", a_valid, 0);
        chk("t1_pops", a_pops - p0, 1);

        // 8 words preloaded: 32 chunks with no bubble
        step(1);
        for (int i = 0; i < 8; i++) push_a(mk_word(16'h2000 + i * 4));
        first = -1; last = -1; cnt = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (a_valid && a_ready) begin
                if (first < 0) first = c;
                last = c;
                cnt++;
            end
        end
        chk("t2_count", cnt, 32);
        chk("t2_span", last - first + 1, 32);

        // RATIO=1: 8 consecutive pops then 8 consecutive outputs
        step(1);
        for (int i = 0; i < 8; i++) push_b(16'h5a00 + 16'(i));
        first = -1; last = -1; cnt = 0; pfirst = -1; plast = -1; pcnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (b_pop) begin
                if (pfirst < 0) pfirst = c;
                plast = c;
                pcnt++;
            end
            if (b_valid && b_ready) begin
                if (first < 0) first = c;
                last = c;
                cnt++;
            end
        end
        chk("t3_pops", pcnt, 8);
        chk("t3_pop_span", plast - pfirst + 1, 8);
        chk("t3_outs", cnt, 8);
        chk("t3_out_span", last - first + 1, 8);
        chk("t3_b_drained", b_exp.size(), 0);

        // backpressure: 5 words queued, out_ready low for 10 cycles
        step(1);
        a_ready = 1'b0;
        p0 = a_pops;
        for (int i = 0; i < 5; i++) push_a(mk_word(16'h3000 + i * 4));
        repeat (10) @(negedge clk);
        chk("t4_pops_stalled", a_pops - p0, 2);
        chk("t4_valid_held", a_valid, 1);
        chk("t4_first_chunk", a_out, 16'h3000);
        step(1);
        a_ready = 1'b1;
        drain_a("t4_drained_in_order");
        chk("t4_pops_total", a_pops - p0, 5);

        // reset mid-word at chunk_idx=2 with LR full and a word still queued
        step(1);
        a_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_a(mk_word(16'h4000 + i * 4));
        step(4);
        a_ready = 1'b1;
        step(2);
        a_ready = 1'b0;
        reset   = 1'b1;
        a_exp.delete();
        a_exp_last.delete();
        @(negedge clk);
        chk("t5_pop_in_reset", a_pop, 0);
        step(1);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_valid_after_reset", a_valid, 0);
        chk("t5_data_after_reset", a_out, 0);
        chk("t5_pop_after_reset", a_pop, 0);
        step(1);
        a_ready = 1'b1;
        push_a(mk_word(16'h6000));
        push_a(mk_word(16'h6004));
        drain_a("t5_restart");

        // fifo runs empty between words: no pop on empty, final chunk once
        step(1);
        p0 = a_pops;
        push_a(mk_word(16'h7000));
        step(6);
        push_a(mk_word(16'h7004));
        drain_a("t6_drained");
        chk("t6_pops", a_pops - p0, 2);
        chk("t6_idle", a_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
